// File: rtl/audio_pkg.sv
// Shared types and helpers for the I2S audio output path.
package audio_pkg;

    typedef logic signed [15:0] sample_t;

    typedef struct packed {
        sample_t left;
        sample_t right;
    } frame_t;

    localparam int FRAME_BITS = 32;

    // (a + b) / 2 with floor rounding; the 17-bit sum cannot overflow.
    function automatic sample_t mix_mono(input sample_t a, input sample_t b);
        logic [16:0] sum;
        sum = {a[15], a} + {b[15], b};
        return sample_t'(sum[16:1]);
    endfunction

endpackage

// File: rtl/audio_clk_en.sv
// Bit-clock divider: free-running half-period counter that toggles bck and
// emits single-cycle strobes on the cycle bck is about to fall or rise.
module audio_clk_en #(
    parameter int HALF_DIV = 20
) (
    input  logic clk32,
    input  logic reset,
    input  logic clear,
    output logic bck,
    output logic fall_en,
    output logic rise_en
);

    localparam int CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [CW-1:0] TC = CW'(HALF_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          bck_q, bck_d;
    logic          tc;

    always_comb begin
        tc    = (cnt_q == TC);
        cnt_d = tc ? '0 : cnt_q + CW'(1);
        bck_d = bck_q ^ tc;
        if (clear) begin
            cnt_d = '0;
            bck_d = 1'b0;
        end
    end

    always_ff @(posedge clk32 or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            bck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            bck_q <= bck_d;
        end
    end

    assign bck     = bck_q;
    assign fall_en = tc & bck_q & ~clear;
    assign rise_en = tc & ~bck_q & ~clear;

endmodule

// File: rtl/audio_i2s_sched.sv
// I2S frame scheduler: one-entry sample buffer, 32-bit frame shifter and
// word-select generation, all clocked from clk32 with divider strobes.
module audio_i2s_sched
    import audio_pkg::*;
#(
    parameter int CLK_HZ    = 32000000,
    parameter int SAMPLE_HZ = 24000,
    // Integer rounding of the frame rate is accepted (25 kHz at defaults).
    parameter int HALF_DIV  = CLK_HZ / (SAMPLE_HZ * 32) / 2
) (
    input  logic        clk32,
    input  logic        reset,
    input  logic        por,
    input  logic        mono,
    input  logic        mute,
    input  logic [15:0] in_left,
    input  logic [15:0] in_right,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        underrun,
    output logic        hp_bck,
    output logic        hp_ws,
    output logic        hp_din,
    output logic        pa_en
);

    localparam int            BIT_W    = $clog2(FRAME_BITS);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS - 1);

    logic bck, fall_en, rise_en;

    audio_clk_en #(
        .HALF_DIV (HALF_DIV)
    ) u_clk_en (
        .clk32   (clk32),
        .reset   (reset),
        .clear   (1'b0),
        .bck     (bck),
        .fall_en (fall_en),
        .rise_en (rise_en)
    );

    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [BIT_W-1:0]      ws_sum;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    frame_t                hold_q, hold_d;
    frame_t                last_q, last_d;
    frame_t                load_val;
    sample_t               mix_val;
    logic                  full_q, full_d;
    logic                  ready_q, ready_d;
    logic                  urun_q, urun_d;
    logic                  ws_q, ws_d;
    logic                  pa_q, pa_d;
    logic                  bck_q, bck_d;
    logic                  frame_start, transfer;

    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        last_d      = last_q;
        full_d      = full_q;
        urun_d      = 1'b0;
        ws_d        = ws_q;
        ws_sum      = '0;
        pa_d        = ~por;
        // Mirrors the divider's bck so hp_bck changes on the same edge as ws/din.
        bck_d       = bck ^ (rise_en | fall_en);

        frame_start = fall_en && (bit_cnt_q == LAST_BIT);
        transfer    = in_valid && ready_q;
        load_val    = full_q ? hold_q : last_q;
        mix_val     = mix_mono(sample_t'(in_left), sample_t'(in_right));

        if (fall_en) begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            ws_sum    = bit_cnt_d + BIT_W'(1);
            ws_d      = ws_sum[BIT_W-1];
            if (frame_start) begin
                shift_d = mute ? '0 : FRAME_BITS'(load_val);
                last_d  = load_val;
                hold_d  = '0;
                full_d  = 1'b0;
                urun_d  = ~full_q;
            end else begin
                shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
            end
        end

        // A consume in the same cycle already used the old contents above.
        if (transfer) begin
            if (mono) begin
                hold_d.left  = mix_val;
                hold_d.right = mix_val;
            end else begin
                hold_d.left  = sample_t'(in_left);
                hold_d.right = sample_t'(in_right);
            end
            full_d = 1'b1;
        end

        ready_d = ~full_d;

        if (por) begin
            bit_cnt_d = LAST_BIT;
            shift_d   = '0;
            hold_d    = '0;
            last_d    = '0;
            full_d    = 1'b0;
            ws_d      = 1'b0;
            ready_d   = 1'b0;
            urun_d    = 1'b0;
        end
    end

    always_ff @(posedge clk32 or posedge reset) begin
        if (reset) begin
            bit_cnt_q <= '0;
            shift_q   <= '0;
            hold_q    <= '0;
            last_q    <= '0;
            full_q    <= 1'b0;
            ready_q   <= 1'b1;
            urun_q    <= 1'b0;
            ws_q      <= 1'b0;
            pa_q      <= 1'b0;
            bck_q     <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            hold_q    <= hold_d;
            last_q    <= last_d;
            full_q    <= full_d;
            ready_q   <= ready_d;
            urun_q    <= urun_d;
            ws_q      <= ws_d;
            pa_q      <= pa_d;
            bck_q     <= bck_d;
        end
    end

    assign in_ready = ready_q;
    assign underrun = urun_q;
    assign hp_bck   = bck_q;
    assign hp_ws    = ws_q;
    assign hp_din   = shift_q[FRAME_BITS-1];
    assign pa_en    = pa_q;

endmodule
